// File: rtl/muldiv_pkg.sv
// Shared types, constants and helpers for the multi-cycle multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned MULDIV_ITER = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } muldiv_state_t;

  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on the {P, Q} / {R, Q} pair.
module muldiv_step (
  input  logic        is_div,
  input  logic [31:0] p,
  input  logic [31:0] q,
  input  logic [31:0] m,
  output logic [31:0] p_next,
  output logic [31:0] q_next
);

  logic [32:0] sum;
  logic [32:0] shifted;
  logic [31:0] diff;
  logic        ge;

  always_comb begin
    sum     = {1'b0, p} + (q[0] ? {1'b0, m} : 33'd0);
    shifted = {p, q[31]};
    ge      = (shifted >= {1'b0, m});
    // A successful trial subtract always leaves a value below m, so 32 bits suffice.
    diff    = shifted[31:0] - m;
    p_next  = p;
    q_next  = q;
    if (is_div) begin
      p_next = ge ? diff : shifted[31:0];
      q_next = {q[30:0], ge};
    end else begin
      p_next = sum[32:1];
      q_next = {sum[0], q[31:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned ITER = MULDIV_ITER
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        Done,
  output logic        DivZero,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  localparam int unsigned CntW = (ITER > 1) ? $clog2(ITER) : 1;

  muldiv_state_t state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0] p_q, p_d, q_q, q_d, m_q, m_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic        dz_q, dz_d;

  muldiv_op_t  op;
  logic        signed_op, div_op;
  logic [31:0] a_mag, b_mag;
  logic [31:0] p_step, q_step;
  logic [63:0] prod, prod_fix;

  assign op        = muldiv_op_t'(Op);
  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign div_op    = (op == OP_DIV) || (op == OP_DIVU);
  assign a_mag     = signed_op ? mag32(A) : A;
  assign b_mag     = signed_op ? mag32(B) : B;
  assign prod      = {p_q, q_q};
  assign prod_fix  = neg_res_q ? (~prod + 64'd1) : prod;

  muldiv_step u_step (
    .is_div (is_div_q),
    .p      (p_q),
    .q      (q_q),
    .m      (m_q),
    .p_next (p_step),
    .q_next (q_step)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    p_d       = p_q;
    q_d       = q_q;
    m_d       = m_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dz_d      = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) state_d = S_IDLE;
        if (Start) begin
          if (div_op && (B == 32'd0)) begin
            state_d = S_DONE;
            dz_d    = 1'b1;
          end else begin
            state_d   = S_RUN;
            cnt_d     = '0;
            is_div_d  = div_op;
            neg_res_d = signed_op & (A[31] ^ B[31]);
            neg_rem_d = signed_op & A[31];
            p_d       = '0;
            // Q holds the multiplier or the dividend; M the multiplicand or the divisor.
            q_d       = div_op ? a_mag : b_mag;
            m_d       = div_op ? b_mag : a_mag;
          end
        end
      end
      S_RUN: begin
        p_d   = p_step;
        q_d   = q_step;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(ITER - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          lo_d = neg_res_q ? (~q_q + 32'd1) : q_q;
          hi_d = neg_rem_q ? (~p_q + 32'd1) : p_q;
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      p_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      p_q       <= p_d;
      q_q       <= q_d;
      m_q       <= m_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dz_q      <= dz_d;
    end
  end

  assign Busy    = (state_q == S_RUN) || (state_q == S_FIX);
  assign Done    = (state_q == S_DONE);
  assign DivZero = dz_q;
  assign Hi      = hi_q;
  assign Lo      = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized bench for muldiv_sequencer against a timeline model built on plain 64-bit arithmetic.
module tb_muldiv_sequencer;

  logic        Clk = 1'b0;
  logic        Reset, Start;
  logic [1:0]  Op;
  logic [31:0] A, B;
  logic        Busy, Done, DivZero;
  logic [31:0] Hi, Lo;

  muldiv_sequencer #(.ITER(32)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .Op      (Op),
    .A       (A),
    .B       (B),
    .Busy    (Busy),
    .Done    (Done),
    .DivZero (DivZero),
    .Hi      (Hi),
    .Lo      (Lo)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Architectural result {HI, LO} from plain signed/unsigned 64-bit arithmetic.
  function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] ua, ub, uq, ur, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = '0;
    case (op)
      2'b00: r = sa * sb;
      2'b01: r = ua * ub;
      2'b10: begin
        sq = sa / sb;
        sr = sa % sb;
        r  = {sr[31:0], sq[31:0]};
      end
      default: begin
        uq = ua / ub;
        ur = ua % ub;
        r  = {ur[31:0], uq[31:0]};
      end
    endcase
    return r;
  endfunction

  // Timeline model: an accepted op is busy for 33 edges and completes on the 34th.
  int          cyc = 0;
  int          busy_til = -10, done_at = -10, dz_at = -10;
  logic [31:0] e_hi = '0, e_lo = '0, p_hi = '0, p_lo = '0;
  logic        e_busy = 1'b0, e_done = 1'b0, e_dz = 1'b0;
  bit          armed = 1'b0;

  always @(posedge Clk) begin
    cyc++;
    if (Reset) begin
      armed    = 1'b1;
      e_hi     = '0;
      e_lo     = '0;
      busy_til = -10;
      done_at  = -10;
      dz_at    = -10;
    end else if (armed) begin
      if (Start && (cyc - 1 > busy_til)) begin
        if (Op[1] && (B == 32'd0)) begin
          done_at = cyc;
          dz_at   = cyc;
        end else begin
          busy_til     = cyc + 32;
          done_at      = cyc + 33;
          {p_hi, p_lo} = ref_op(Op, A, B);
        end
      end
      if (cyc == done_at && cyc != dz_at) begin
        e_hi = p_hi;
        e_lo = p_lo;
      end
    end
    e_busy = (cyc <= busy_til);
    e_done = (cyc == done_at);
    e_dz   = (cyc == dz_at);
  end

  always @(negedge Clk) begin
    if (armed) begin
      check("cycle_flags", {61'd0, Busy, Done, DivZero}, {61'd0, e_busy, e_done, e_dz});
      check("cycle_hilo", {Hi, Lo}, {e_hi, e_lo});
    end
  end

  // Call at a negedge; returns at the negedge where Done is seen.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_n, output bit dz_seen);
    Start = 1'b1;
    Op = op;
    A = a;
    B = b;
    lat = 0;
    busy_n = 0;
    dz_seen = 1'b0;
    forever begin
      @(negedge Clk);
      lat++;
      if (lat == 1) begin
        Start = 1'b0;
        Op = 2'($urandom);
        A = $urandom;
        B = $urandom;
      end
      if (Busy) busy_n++;
      if (DivZero) dz_seen = 1'b1;
      if (Done) break;
      if (lat >= 100) begin
        check("done_wait", {63'd0, Done}, 64'd1);
        break;
      end
    end
  endtask

  task automatic lit_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] xh, input logic [31:0] xl);
    int lat, bn;
    bit dz;
    check({name, "_model"}, ref_op(op, a, b), {xh, xl});
    run_op(op, a, b, lat, bn, dz);
    check({name, "_hilo"}, {Hi, Lo}, {xh, xl});
    check({name, "_lat"}, 64'(lat), 64'd34);
  endtask

  logic [31:0] specials [6] = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'd7};

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 3))
      0: return specials[$urandom_range(0, 5)];
      1: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat, bn, dcnt;
    bit dz;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    Reset = 1'b1;
    Start = 1'b0;
    Op = 2'b00;
    A = '0;
    B = '0;
    repeat (3) @(negedge Clk);
    check("reset_flags", {61'd0, Busy, Done, DivZero}, 64'd0);
    check("reset_hilo", {Hi, Lo}, 64'd0);
    Reset = 1'b0;
    @(negedge Clk);

    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bn, dz);
    check("multu_max_hilo", {Hi, Lo}, 64'hFFFFFFFE_00000001);
    check("multu_max_lat", 64'(lat), 64'd34);
    check("multu_max_busy", 64'(bn), 64'd33);

    lit_op("mult_neg7x3", 2'b00, 32'hFFFFFFF9, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFEB);
    lit_op("mult_min_sq", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);
    lit_op("div_neg7_2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    lit_op("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
    lit_op("div_min_m1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    lit_op("divu_setup", 2'b11, 32'h451, 32'h20, 32'h11, 32'h22);

    run_op(2'b11, 32'd5, 32'd0, lat, bn, dz);
    check("divzero_lat", 64'(lat), 64'd1);
    check("divzero_flag", {63'd0, dz}, 64'd1);
    check("divzero_hilo", {Hi, Lo}, 64'h11_00000022);
    check("divzero_busy", 64'(bn), 64'd0);
    @(negedge Clk);

    // A Start during RUN (here a would-be divide-by-zero) must be ignored.
    Start = 1'b1; Op = 2'b01; A = 32'd3; B = 32'd5;
    @(negedge Clk);
    Start = 1'b0;
    repeat (8) @(negedge Clk);
    Start = 1'b1; Op = 2'b11; A = 32'd1; B = 32'd0;
    @(negedge Clk);
    Start = 1'b0;
    dcnt = 0;
    repeat (40) begin
      @(negedge Clk);
      if (Done) dcnt++;
    end
    check("ignore_start_dones", 64'(dcnt), 64'd1);
    check("ignore_start_hilo", {Hi, Lo}, 64'd15);

    run_op(2'b01, 32'd2, 32'd3, lat, bn, dz);
    check("b2b_first", {Hi, Lo}, 64'd6);
    run_op(2'b11, 32'd100, 32'd7, lat, bn, dz);
    check("b2b_lat", 64'(lat), 64'd34);
    check("b2b_hilo", {Hi, Lo}, 64'h2_0000000E);

    // Reset while the counter reads 10.
    Start = 1'b1; Op = 2'b01; A = 32'h1234; B = 32'h5678;
    @(negedge Clk);
    Start = 1'b0;
    repeat (10) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check("midrun_reset_flags", {61'd0, Busy, Done, DivZero}, 64'd0);
    check("midrun_reset_hilo", {Hi, Lo}, 64'd0);
    Reset = 1'b0;
    @(negedge Clk);
    lit_op("after_reset_6x7", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42);

    for (int i = 0; i < 150; i++) begin
      rop = 2'($urandom);
      ra  = pick();
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
      run_op(rop, ra, rb, lat, bn, dz);
      if (rop[1] && rb == 32'd0) begin
        check("rand_dz_lat", 64'(lat), 64'd1);
      end else begin
        check("rand_lat", 64'(lat), 64'd34);
        check("rand_hilo", {Hi, Lo}, ref_op(rop, ra, rb));
      end
      repeat ($urandom_range(0, 2)) @(negedge Clk);
    end

    repeat (3) @(negedge Clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
